// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 16x oversampling tick, mid-bit sampling,
// a single-entry holding register with acknowledge, and framing/overrun pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam int unsigned CNT_W    = (TICK_DIV >= 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_div_check
        $error("uart_rx: CLK_FREQ / (BAUD*16) must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [3:0]       r_bit_tick;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_tick;
    logic w_start;

    assign w_tick  = (r_tick_cnt == TICK_MAX);
    // Start-edge detection; shared by the tick divider and the FSM so both realign together.
    assign w_start = (r_state == StIdle) && !r_rx_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    // 16x baud tick divider, phase-aligned to the detected start edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_start || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Receive FSM with registered data/status outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= StIdle;
            r_bit_tick   <= 4'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            // Acknowledge clears the holding register; a same-cycle delivery below overrides.
            if (rd_ack && r_data_valid) begin
                r_data_valid <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (!r_rx_s) begin
                        r_state    <= StStart;
                        r_bit_tick <= 4'd0;
                        r_bit_idx  <= 3'd0;
                    end
                end
                StStart: begin
                    if (w_tick) begin
                        if (r_bit_tick == 4'd7) begin
                            // Mid start bit: a high line means the edge was a glitch.
                            if (r_rx_s) begin
                                r_state <= StIdle;
                            end else begin
                                r_state    <= StData;
                                r_bit_tick <= 4'd0;
                            end
                        end else begin
                            r_bit_tick <= r_bit_tick + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (w_tick) begin
                        r_bit_tick <= r_bit_tick + 4'd1;
                        if (r_bit_tick == 4'd15) begin
                            r_shift[r_bit_idx] <= r_rx_s;
                            r_bit_idx          <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= StStop;
                            end
                        end
                    end
                end
                StStop: begin
                    if (w_tick) begin
                        r_bit_tick <= r_bit_tick + 4'd1;
                        if (r_bit_tick == 4'd15) begin
                            if (r_rx_s) begin
                                r_state <= StIdle;
                                if (!r_data_valid || rd_ack) begin
                                    r_data_out   <= r_shift;
                                    r_data_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= StWaitHigh;
                            end
                        end
                    end
                end
                StWaitHigh: begin
                    // Line stuck low (break): wait for it to recover before hunting a new start.
                    if (r_rx_s) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != StIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk_in frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate; frame format is fixed 8N1, LSB first.
REQ-003 SHALL derive TICK_DIV = CLK_FREQ / (BAUD*16) using integer truncation; TICK_DIV >= 2 is required, otherwise elaboration is an error.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rd_ack, input, 1 bit: consumer acknowledge of data_out.
REQ-008 SHALL have port data_out, output, 8 bits: the last received byte.
REQ-009 SHALL have port data_valid, output, 1 bit: data_out holds an unacknowledged byte.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse on a dropped byte.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-014 SHALL generate a 16x tick:
- counter runs 0..TICK_DIV-1; tick is asserted when the count equals TICK_DIV-1, then the count wraps to 0.
- counter is forced to 0 on the IDLE->START transition.
REQ-015 SHALL implement the state machine IDLE, START, DATA, STOP, WAIT_HIGH, with the transitions below.
REQ-016 IDLE: on rx_s == 0, go to START and clear the tick-in-bit counter (4 bits) and the bit index (3 bits).
REQ-017 START: on the 8th tick (bit middle), sample rx_s:
- 1: glitch; return to IDLE with no output activity.
- 0: go to DATA and clear the tick-in-bit counter.
REQ-018 DATA:
- On every 16th tick, shift rx_s into the shift register at bit[index], LSB first.
- After index 7 is sampled, go to STOP.
REQ-019 STOP: on the 16th tick, sample rx_s:
- 1 = valid stop bit: deliver the byte per REQ-020/021 and return to IDLE the next cycle.
- 0 = framing error: pulse frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
REQ-020 Delivery when data_valid == 0, or when rd_ack == 1 in the same cycle:
- data_out is loaded with the shift register and data_valid = 1 on the cycle after the stop sample.
- No overrun is signalled.
REQ-021 Delivery when data_valid == 1 and rd_ack == 0:
- The new byte is dropped; data_out and data_valid are unchanged.
- overrun pulses for 1 cycle.
REQ-022 WAIT_HIGH: remain until rx_s == 1 (break/line-low condition), then go to IDLE; no byte is delivered and no further frame_err pulses occur.
REQ-023 rd_ack while data_valid == 1 SHALL clear data_valid on the next cycle; data_out SHALL hold its value.
REQ-024 rd_ack while data_valid == 0 SHALL be ignored.
REQ-025 data_out SHALL change only on delivery.
REQ-026 Latency: data_valid SHALL rise exactly 1 clk_in cycle after the stop-bit sampling tick, which falls about 9.5 bit times plus 2 synchronizer cycles after the start falling edge.
REQ-027 The receiver SHALL accept back-to-back frames: a new start edge is detected in IDLE with no idle-bit requirement beyond the stop bit.

Reset
REQ-028 reset == 1 at a clock edge SHALL force:
- state IDLE
- synchronizer flops to 1
- tick and bit counters to 0
- shift register to 0x00
- data_out = 0x00
- data_valid = 0, frame_err = 0, overrun = 0, busy = 0
REQ-029 reset asserted mid-frame SHALL abandon the frame with no delivery and no error pulse.
REQ-030 After reset deasserts, reception SHALL restart from the next falling edge of rx_s.

Verification
All scenarios use CLK_FREQ=1_536_000, BAUD=9600: TICK_DIV=10, 160 clk_in per bit.
REQ-031 Send 0xA5, valid stop, rd_ack held low -> data_out=0xA5, data_valid=1 one cycle after the stop sample, frame_err=0, overrun=0.
REQ-032 Send 0x3C without ack, then 0xC3 -> overrun pulses once, data_out stays 0x3C; rd_ack, then send 0x81 -> data_out=0x81.
REQ-033 Send 0x55 with the stop bit driven 0, line held low for 3 bit times, then high -> frame_err is a single 1-cycle pulse, data_valid=0, busy falls only after the line returns high.
REQ-034 Low glitch on rx_in of 40 clk_in -> START rejects it, returns to IDLE, no data_valid, no errors.
REQ-035 Assert reset at data bit 4 of 0xFF, release, then send 0x12 -> no delivery of 0xFF; data_out=0x12, data_valid=1.
REQ-036 Stop bit of 0x7E completes in the same cycle as rd_ack for the prior byte 0x01 -> data_out=0x7E, data_valid stays 1, overrun=0.
